// File: rtl/bias2_pkg.sv
// Shared types and constants for the output-layer bias delta generator.
// Feature macro: BIAS2_DELTA_ROUND_EN selects round-half-up scaling.
package bias2_pkg;

  localparam int N_OUT   = 5;
  localparam int ERR_W   = 32;
  localparam int DELTA_W = 16;

  localparam logic [3:0] CTRL_UPDATE = 4'b0001;
  localparam logic [3:0] CTRL_HOLD   = 4'b0000;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SCALE,
    ISSUE
  } state_e;

  typedef logic signed [ERR_W-1:0]   err_t;
  typedef logic signed [DELTA_W-1:0] delta_t;

  // Step skips 0 so the bank is never inhibited once updates start
  function automatic logic [3:0] step_next(logic [3:0] s);
    return (s == 4'd15) ? 4'd1 : s + 4'd1;
  endfunction

endpackage

// File: rtl/bias2_delta_gen_if.sv
// Error-term stream: one signed lane value per valid/ready beat.
// Feature macro: BIAS2_DELTA_ROUND_EN (no effect on this interface).
interface bias2_delta_gen_if;
  import bias2_pkg::*;

  logic err_valid;
  logic err_ready;
  err_t err_data;

  modport master (
    output err_valid,
    output err_data,
    input  err_ready
  );

  modport slave (
    input  err_valid,
    input  err_data,
    output err_ready
  );

endinterface

// File: rtl/bias2_delta_sat.sv
// One lane: optional round, arithmetic shift, negate, saturate.
// Feature macro: BIAS2_DELTA_ROUND_EN adds 2^(LR_SHIFT-1) before the shift.
module bias2_delta_sat
  import bias2_pkg::*;
#(
  parameter int LR_SHIFT = 4
) (
  input  err_t   err_i,
  output delta_t delta_o
);

  localparam int XW = ERR_W + 1;
  localparam int HS = (LR_SHIFT > 0) ? LR_SHIFT - 1 : 0;

`ifdef BIAS2_DELTA_ROUND_EN
  localparam int RND_I = (LR_SHIFT > 0) ? (1 << HS) : 0;
`else
  localparam int RND_I = 0;
`endif

  localparam logic signed [XW-1:0] RNDV = XW'(RND_I);
  localparam logic signed [XW-1:0] MAXV =
    XW'((1 << (DELTA_W - 1)) - 1);
  localparam logic signed [XW-1:0] MINV =
    XW'(-(1 << (DELTA_W - 1)));

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] rnd;
  logic signed [XW-1:0] shf;
  logic signed [XW-1:0] neg;

  // Headroom bit keeps the rounding add and negation from wrapping
  always_comb begin
    ext = {err_i[ERR_W-1], err_i};
    rnd = ext + RNDV;
    shf = rnd >>> LR_SHIFT;
    neg = -shf;
    if (neg > MAXV) begin
      delta_o = MAXV[DELTA_W-1:0];
    end else if (neg < MINV) begin
      delta_o = MINV[DELTA_W-1:0];
    end else begin
      delta_o = neg[DELTA_W-1:0];
    end
  end

endmodule

// File: rtl/bias2_delta_gen.sv
// Collects five error lanes, scales them and strobes one bias update.
// Feature macro: BIAS2_DELTA_ROUND_EN selects round-half-up scaling.
module bias2_delta_gen
  import bias2_pkg::*;
#(
  parameter int LR_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  bias2_delta_gen_if.slave  err,
  input  logic              abort,
  output logic [3:0]        ctrl,
  output logic [3:0]        step,
  output delta_t            deltab2_1,
  output delta_t            deltab2_2,
  output delta_t            deltab2_3,
  output delta_t            deltab2_4,
  output delta_t            deltab2_5,
  output logic              busy
);

  localparam logic [2:0] LAST = 3'(N_OUT - 1);

  state_e     state_q;
  logic [2:0] idx_q;
  err_t       err_q   [N_OUT];
  delta_t     delta_q [N_OUT];
  delta_t     delta_d [N_OUT];
  logic [3:0] ctrl_q;
  logic [3:0] step_q;
  logic       busy_q;
  logic       collecting;
  logic       acc;

  // abort masks ready so it always wins over a coincident beat
  assign collecting    = (state_q == IDLE) || (state_q == COLLECT);
  assign err.err_ready = collecting && !abort;
  assign acc           = err.err_valid && err.err_ready;

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    bias2_delta_sat #(
      .LR_SHIFT(LR_SHIFT)
    ) u_sat (
      .err_i  (err_q[g]),
      .delta_o(delta_d[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      ctrl_q  <= CTRL_HOLD;
      step_q  <= 4'd0;
      busy_q  <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        err_q[i]   <= '0;
        delta_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            err_q[0] <= err.err_data;
            idx_q    <= 3'd1;
            state_q  <= COLLECT;
          end else begin
            idx_q <= 3'd0;
          end
        end
        COLLECT: begin
          if (abort) begin
            idx_q   <= 3'd0;
            state_q <= IDLE;
          end else if (acc) begin
            err_q[idx_q] <= err.err_data;
            if (idx_q == LAST) begin
              idx_q   <= 3'd0;
              busy_q  <= 1'b1;
              state_q <= SCALE;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        SCALE: begin
          for (int i = 0; i < N_OUT; i++) begin
            delta_q[i] <= delta_d[i];
          end
          step_q  <= step_next(step_q);
          ctrl_q  <= CTRL_UPDATE;
          state_q <= ISSUE;
        end
        ISSUE: begin
          ctrl_q  <= CTRL_HOLD;
          busy_q  <= 1'b0;
          idx_q   <= 3'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ctrl      = ctrl_q;
  assign step      = step_q;
  assign busy      = busy_q;
  assign deltab2_1 = delta_q[0];
  assign deltab2_2 = delta_q[1];
  assign deltab2_3 = delta_q[2];
  assign deltab2_4 = delta_q[3];
  assign deltab2_5 = delta_q[4];

endmodule

// File: doc/bias2_delta_gen.md
Name: bias2_delta_gen

Overview:
- Producer end of the output-layer bias update interface. Drives the 5 signed 16-bit bias deltas plus the ctrl/step qualifiers that the bias2 register bank consumes.
- Accepts output-layer error terms as a valid/ready stream, one lane per beat.
- Converts each error to a bias delta: negate, shift-scale by the learning rate, saturate.
- Issues exactly one update strobe per complete 5-lane error set.

Parameters:
- N_OUT, 5, number of output lanes; fixed by the bias bank port count.
- ERR_W, 32, signed error input width.
- DELTA_W, 16, signed delta output width.
- LR_SHIFT, 4, learning rate as 2^-LR_SHIFT; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- err_valid  in  1  error beat valid.
- err_ready  out  1  error beat accepted when valid & ready.
- err_data  in  ERR_W  signed error for the current lane; lanes arrive in order 0..4.
- abort  in  1  discard a partial collection.
- ctrl  out  4  4'b0001 = apply update; 4'b0000 = hold.
- step  out  4  update sequence number; never 0 after the first update.
- deltab2_1..deltab2_5  out  DELTA_W each  signed deltas for lanes 0..4.
- busy  out  1  high in SCALE and ISSUE.

Behaviour:
- Reset values: state=IDLE, lane index=0, all error holding regs=0, all deltab2_*=0, ctrl=4'b0000, step=0, busy=0.
- States and transitions:
  - IDLE: err_ready=1. An accepted beat stores to lane 0 and moves to COLLECT with index=1.
  - COLLECT: err_ready=1. Each accepted beat stores to lane[index] and increments index. Accepting lane 4 moves to SCALE.
  - SCALE: one cycle, err_ready=0. All 5 deltas are computed and registered at the edge that leaves SCALE. Step counter increments at the same edge. Moves to ISSUE.
  - ISSUE: one cycle, err_ready=0, ctrl=4'b0001. Returns to IDLE with index=0.
- Latency: the 5th beat handshakes at edge t. SCALE is the state during cycle t..t+1. ISSUE is the state during t+1..t+2. The bias bank applies the update at edge t+2.
- ctrl is 4'b0001 only while in ISSUE. Exactly one cycle per set, so exactly one bank update per set.
- deltab2_* change only at the SCALE exit edge. They are stable throughout ISSUE and hold until the next SCALE.
- step wraps 15 -> 1, skipping 0 so the bank is never inhibited once updates have started. step=0 only before the first update.
- Arithmetic, per lane:
  - Sign-extend err to ERR_W+1 bits.
  - Arithmetic right shift by LR_SHIFT (truncation toward -inf).
  - Negate.
  - Saturate to [-32768, 32767].
  - No wrap-around is permitted.
- abort:
  - In IDLE or COLLECT: clears index to 0, returns to IDLE, and drops the partial set. err_ready is forced low in the abort cycle, so abort wins over a simultaneous beat.
  - In SCALE or ISSUE: ignored; the set completes.
- err_valid with err_ready=0: no transfer. The source must hold the beat.
- Reset asserted mid-operation (any state): immediate return to reset values. A pending ISSUE is cancelled and ctrl drops to 0000 asynchronously.

Optional Feature:
- Macro: BIAS2_DELTA_ROUND_EN.
- Defined: round-half-up before the shift, i.e. add 2^(LR_SHIFT-1) when LR_SHIFT>0, computed in ERR_W+1 bits. Then negate and saturate as normal.
- Undefined: plain truncating arithmetic shift.
- Latency and handshake are identical in both builds.

Decomposition:
- bias2_pkg holds:
  - N_OUT, ERR_W, DELTA_W.
  - CTRL_UPDATE=4'b0001 and CTRL_HOLD=4'b0000.
  - Typedef for the state enum {IDLE, COLLECT, SCALE, ISSUE}.
  - Typedefs err_t and delta_t.
- One sub-module, bias2_delta_sat: purely combinational shift/round/negate/saturate for one lane, instantiated N_OUT times inside SCALE's datapath.

Test Plan (all with LR_SHIFT=4):
- Reset: assert rst_n=0 mid-COLLECT -> err_ready=1, ctrl=0000, step=0, all deltas=0 after release.
- Basic set: errs 160, -32, 0, 15, -16 -> deltas -10, 2, 0, 0, 1; ctrl=0001 for exactly 1 cycle, 2 cycles after the 5th handshake; step=1.
- Rounding build (BIAS2_DELTA_ROUND_EN): same set -> deltas -10, 2, 0, -1, 1.
- Saturation: err 0x7FFFFFFF -> -32768; err 0x80000000 -> 32767; err 524272 -> -32767 (unsaturated).
- Abort: 3 beats, then abort asserted together with a valid beat -> beat not accepted, index=0, no ctrl pulse. The next 5 beats produce a single update.
- Step wrap and backpressure: 16 consecutive sets with err_valid held during SCALE/ISSUE -> no beats lost; step sequence 1..15, 1; ctrl never 0001 with step=0.
